// File: rtl/float_div_12.sv
// float_div_12: iterative divider for the 12-bit float format
// (sign[11], exponent[10:6] bias 15, mantissa[5:0] with hidden 1).
// Restoring radix-2 division, one quotient bit per clock.
// Optional macro FLOAT_DIV_12_ROUND_EN: one extra guard iteration and
// round-half-up of the mantissa (latency 11 instead of 10).
//
// Handshake: an operand set is accepted on a rising edge where
// valid_i=1 and ready_o=1; ready_o is high only in IDLE and valid_i is
// ignored (not queued) otherwise. Inputs need not be held after the
// accepting edge. valid_o is a one-cycle strobe; data_div_o and dbz_o
// are held stable until the next valid_o.
module float_div_12 #(
    parameter int DATA_W = 12,
    parameter int EXP_W  = 5,
    parameter int MAN_W  = 6,
    parameter int BIAS   = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_1_i,
    input  logic [DATA_W-1:0] data_2_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_div_o,
    output logic              dbz_o
);

`ifdef FLOAT_DIV_12_ROUND_EN
    localparam int ITER = MAN_W + 3;
`else
    localparam int ITER = MAN_W + 2;
`endif

    localparam int EXP_RAW_W = EXP_W + 2;
    localparam int REM_W     = MAN_W + 2;
    localparam int CNT_W     = 4;

    localparam logic [CNT_W-1:0]            CNT_LAST = CNT_W'(ITER - 1);
    localparam logic signed [EXP_RAW_W-1:0] EXP_ZERO = '0;
    localparam logic signed [EXP_RAW_W-1:0] EXP_SAT  = EXP_RAW_W'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0]            EXP_ONES = '1;
    localparam logic [MAN_W-1:0]            MAN_ONES = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // FSM state is kept as a named enum so checkers can bind to it.
    state_t state, state_nxt;

    logic [REM_W-1:0]            rem_q;
    logic [MAN_W:0]              b_q;
    logic [ITER-1:0]             quo_q;
    logic [CNT_W-1:0]            cnt_q;
    logic                        sign_q;
    logic signed [EXP_RAW_W-1:0] exp_raw_q;
    logic                        zd_q;
    logic                        zv_q;
    logic [DATA_W-1:0]           data_div_q;
    logic                        dbz_q;

    logic signed [EXP_RAW_W-1:0] exp_raw_in;
    logic [REM_W:0]              trial;
    logic                        qbit;
    logic [REM_W-1:0]            rem_sel;
    logic [REM_W-1:0]            rem_nxt;

    logic [MAN_W-1:0]            man_n;
    logic signed [EXP_RAW_W-1:0] exp_n;
    logic [DATA_W-1:0]           res_word;
    logic                        res_dbz;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; CALC always runs its full iteration count so
    // latency does not depend on the operand class.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (valid_i) state_nxt = S_CALC;
            S_CALC: if (cnt_q == CNT_LAST) state_nxt = S_NORM;
            S_NORM: state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign ready_o    = (state == S_IDLE);
    assign valid_o    = (state == S_DONE);
    assign data_div_o = data_div_q;
    assign dbz_o      = dbz_q;

    // Operand decode and one restoring-division step.
    always_comb begin
        exp_raw_in = EXP_RAW_W'({2'b00, data_1_i[DATA_W-2 -: EXP_W]})
                   - EXP_RAW_W'({2'b00, data_2_i[DATA_W-2 -: EXP_W]})
                   + EXP_RAW_W'(BIAS - 1);
        trial   = {1'b0, rem_q} - {2'b00, b_q};
        qbit    = ~trial[REM_W];
        rem_sel = qbit ? trial[REM_W-1:0] : rem_q;
        rem_nxt = rem_sel << 1;
    end

    // Normalisation and special-case selection for the finished quotient.
    always_comb begin
        man_n    = '0;
        exp_n    = exp_raw_q;
        res_word = '0;
        res_dbz  = 1'b0;

        // quo_q lies in [2^(ITER-2), 2^ITER): top bit decides the shift.
        if (quo_q[ITER-1]) begin
            man_n = quo_q[ITER-2 -: MAN_W];
            exp_n = exp_raw_q + EXP_RAW_W'(1);
        end else begin
            man_n = quo_q[ITER-3 -: MAN_W];
        end

`ifdef FLOAT_DIV_12_ROUND_EN
        // Round half up on the guard bit; a mantissa carry bumps the exponent.
        if (quo_q[ITER-1] ? quo_q[1] : quo_q[0]) begin
            if (man_n == MAN_ONES) begin
                man_n = '0;
                exp_n = exp_n + EXP_RAW_W'(1);
            end else begin
                man_n = man_n + MAN_W'(1);
            end
        end
`endif

        if (zv_q) begin
            res_word = {sign_q, EXP_ONES, MAN_ONES};
            res_dbz  = 1'b1;
        end else if (zd_q) begin
            res_word = '0;
        end else if (exp_n <= EXP_ZERO) begin
            res_word = '0;
        end else if (exp_n >= EXP_SAT) begin
            res_word = {sign_q, EXP_ONES, MAN_ONES};
        end else begin
            res_word = {sign_q, exp_n[EXP_W-1:0], man_n};
        end
    end

    // Datapath registers: operand capture, iteration, result capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q      <= '0;
            b_q        <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            exp_raw_q  <= '0;
            zd_q       <= 1'b0;
            zv_q       <= 1'b0;
            data_div_q <= '0;
            dbz_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid_i) begin
                        // Remainder starts at the dividend mantissa with hidden 1.
                        rem_q     <= {1'b0, 1'b1, data_1_i[MAN_W-1:0]};
                        b_q       <= {1'b1, data_2_i[MAN_W-1:0]};
                        quo_q     <= '0;
                        cnt_q     <= '0;
                        sign_q    <= data_1_i[DATA_W-1] ^ data_2_i[DATA_W-1];
                        exp_raw_q <= exp_raw_in;
                        zd_q      <= (data_1_i[DATA_W-2:0] == '0);
                        zv_q      <= (data_2_i[DATA_W-2:0] == '0);
                    end
                end
                S_CALC: begin
                    rem_q <= rem_nxt;
                    quo_q <= {quo_q[ITER-2:0], qbit};
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                S_NORM: begin
                    data_div_q <= res_word;
                    dbz_q      <= res_dbz;
                    cnt_q      <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/float_div_12.md
Name: float_div_12

Overview:
- Iterative divider for the 12-bit float format used by the datapath.
- Format: sign[11], exponent[10:6] with bias 15, mantissa[5:0] with hidden 1.
- Division is the inverse of the pipelined 12-bit multiplier. It uses restoring radix-2 division, one quotient bit per clock.
- Sits beside the multiplier in the float_arith group. Used for normalisation/scaling paths where throughput of one result per ~10 cycles is acceptable.

Parameters:
- DATA_W, 12, total word width.
- EXP_W, 5, exponent width.
- MAN_W, 6, stored mantissa width.
- BIAS, 15, exponent bias.
- Only the defaults are required to be verified.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- valid_i  in  1  operand strobe; accepted only when ready_o=1.
- data_1_i  in  12  dividend.
- data_2_i  in  12  divisor.
- ready_o  out  1  high only in IDLE.
- valid_o  out  1  one-cycle result strobe.
- data_div_o  out  12  quotient; held stable until the next valid_o.
- dbz_o  out  1  divide-by-zero flag; qualified by valid_o, held with data_div_o.

Behaviour:
- Reset (rst_i=1 at clock edge): state=IDLE, ready_o=1, valid_o=0, data_div_o=0, dbz_o=0, iteration counter=0. This applies in any state, including mid-CALC; an aborted operation never produces valid_o.
- States: IDLE -> CALC -> NORM -> DONE -> IDLE.
- IDLE:
  - On valid_i=1, latch A={1,man_a}, B={1,man_b}, sign=sa^sb, and signed 7-bit exp_raw=ea-eb+BIAS-1.
  - Latch zero flags: zd=(data_1_i[10:0]==0), zv=(data_2_i[10:0]==0).
  - Clear the partial remainder to A and go to CALC.
  - Exponent 0 with nonzero mantissa is treated as normal with hidden 1 (same as the multiplier).
- CALC: 8 cycles. Each cycle: trial = rem - B. If trial>=0, qbit=1 and rem=trial; else qbit=0. Then rem<<=1 and q={q[6:0],qbit}. Result: q=floor(A*128/B), range 64..254.
- NORM:
  - If q[7]=1: man=q[6:1], exp=exp_raw+1.
  - Else: man=q[5:0], exp=exp_raw.
  - Truncation only; no rounding.
- NORM priority (first match wins):
  1. zv=1: result {sign,5'h1F,6'h3F}, dbz=1. This includes 0/0.
  2. zd=1: result 12'h000, dbz=0.
  3. exp<=0 (underflow): result 12'h000 (sign forced 0).
  4. exp>=31 (overflow): result {sign,5'h1F,6'h3F}.
  5. Otherwise: {sign,exp[4:0],man}.
- DONE: register the result into data_div_o/dbz_o and assert valid_o for exactly one cycle. Return to IDLE on the next edge.
- Latency: fixed for every operand class, including special cases (CALC always runs). valid_o is high in the 10th cycle after the accepting edge. ready_o deasserts the cycle after acceptance and reasserts with valid_o's falling edge.
- Throughput: one operation per 11 cycles. valid_i while ready_o=0 is ignored (not queued). Inputs need not be held after acceptance.

Optional Feature:
- Macro: FLOAT_DIV_12_ROUND_EN.
- When defined:
  - CALC runs 9 iterations; the extra LSB is the guard bit.
  - After selecting man, add the guard bit (round-half-up). A mantissa carry-out (63+1) sets man=0 and exp+=1. This occurs before the underflow/overflow checks.
  - Latency becomes 11 cycles.
- When undefined: truncation, 8 iterations, 10-cycle latency.

Test Plan:
- 0x3C0 (1.0) / 0x400 (2.0) -> valid_o 10 cycles after accept, data_div_o=0x380 (0.5), dbz_o=0.
- 0x3C0 / 0x420 (3.0) -> 0x355 (truncated 0.332). Also 0x420 / 0x3C0 -> 0x420. Also 0xC60 (-6.0) / 0x400 -> 0xC20 (-3.0).
- Special cases:
  - 0x3C0 / 0x000 -> 0x7FF, dbz_o=1.
  - 0x000 / 0x3C0 -> 0x000, dbz_o=0.
  - 0x800 / 0x000 -> 0xFFF, dbz_o=1.
- Range limits:
  - 0x040 / 0x780 (exp 1/30) -> 0x000 (underflow).
  - 0x780 / 0x040 -> 0x7FF (overflow saturate).
- Handshake: pulse valid_i with 0x400/0x3C0, then drive valid_i=1 with other operands every cycle while busy -> the second set is ignored, exactly one valid_o with 0x400. The next accept occurs only when ready_o=1.
- Reset mid-op: assert rst_i in the 4th CALC cycle -> next cycle ready_o=1, valid_o=0, data_div_o=0. No valid_o for the aborted operation; a new operation afterwards completes normally.
